// File: rtl/bcd_score_acc.sv
// Digit-serial packed-BCD score accumulator with saturation, best-score
// tracking and a ready/done handshake toward the display driver.
module bcd_score_acc #(
  parameter int          DIGITS  = 4,
  parameter logic [15:0] REWARD  = {4'd4, 4'd3, 4'd2, 4'd1},
  parameter logic [15:0] PENALTY = {4'd8, 4'd5, 4'd3, 4'd1}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                hit,
  input  logic                miss,
  input  logic [1:0]          level,
  output logic                ready,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] best,
  output logic                done,
  output logic                sat
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

  state_t             state, state_next;
  logic [W-1:0]       work;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               op_sub;
  logic [3:0]         opnd;

  logic               accept;
  logic               last_digit;
  logic [3:0]         digit_in;
  logic [3:0]         opnd_eff;
  logic [3:0]         digit_out;
  logic               carry_out;
  logic [W-1:0]       result;

  // One BCD digit add: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add_digit(input logic [3:0] d,
                                               input logic [3:0] a,
                                               input logic       cin);
    logic [4:0] s;
    s = {1'b0, d} + {1'b0, a} + {4'b0000, cin};
    if (s > 5'd9) begin
      s = s - 5'd10;
      return {1'b1, s[3:0]};
    end
    return {1'b0, s[3:0]};
  endfunction

  // One BCD digit subtract: returns {borrow_out, digit}.
  function automatic logic [4:0] bcd_sub_digit(input logic [3:0] d,
                                               input logic [3:0] a,
                                               input logic       bin);
    logic signed [4:0] t;
    t = signed'({1'b0, d}) - signed'({1'b0, a}) - signed'({4'b0000, bin});
    if (t < 5'sd0) begin
      t = t + 5'sd10;
      return {1'b1, t[3:0]};
    end
    return {1'b0, t[3:0]};
  endfunction

  // Clamp on overflow out of the most significant digit.
  function automatic logic [W-1:0] saturate(input logic [W-1:0] w,
                                            input logic         ovf,
                                            input logic         is_sub);
    if (!ovf)   return w;
    if (is_sub) return '0;
    return {DIGITS{4'h9}};
  endfunction

  // Accept decode and the single-digit arithmetic slice used during RUN.
  always_comb begin
    accept     = (state == IDLE) && (hit ^ miss) && !clear;
    last_digit = (idx == IDX_W'(DIGITS - 1));
    digit_in   = work[{idx, 2'b00} +: 4];
    opnd_eff   = (idx == '0) ? opnd : 4'd0;
    if (op_sub) {carry_out, digit_out} = bcd_sub_digit(digit_in, opnd_eff, carry);
    else        {carry_out, digit_out} = bcd_add_digit(digit_in, opnd_eff, carry);
    result     = saturate(work, carry, op_sub);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic; clear forces IDLE from anywhere.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_digit) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Datapath: operand latch, digit-serial working register, commit and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      score  <= '0;
      best   <= '0;
      ready  <= 1'b1;
      done   <= 1'b0;
      sat    <= 1'b0;
      work   <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      op_sub <= 1'b0;
      opnd   <= 4'd0;
    end else if (clear) begin
      score <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
      sat   <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      sat  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_sub <= miss;
            opnd   <= miss ? PENALTY[{level, 2'b00} +: 4] : REWARD[{level, 2'b00} +: 4];
            work   <= score;
            idx    <= '0;
            carry  <= 1'b0;
            ready  <= 1'b0;
          end
        end
        RUN: begin
          work[{idx, 2'b00} +: 4] <= digit_out;
          carry                   <= carry_out;
          idx                     <= idx + IDX_W'(1);
        end
        COMMIT: begin
          score <= result;
          if (result > best) best <= result;
          done  <= 1'b1;
          sat   <= carry;
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bcd_score_acc.md
# bcd_score_acc

Parameterised, clocked BCD score accumulator for the game datapath. It sits between the hit/miss event logic and the seven-segment display driver. On each accepted hit or miss it adds a level-dependent reward to, or subtracts a level-dependent penalty from, a DIGITS-wide packed-BCD score. The arithmetic runs digit-serially, one digit per cycle, and the result saturates at all-9s and at zero. It also tracks a best-score register and exposes a ready/done handshake, so the display never sees a partial value.

## Interface
- DIGITS, 4: number of BCD digits in score/best (≥1).
- REWARD, {4'd4,4'd3,4'd2,4'd1}: packed per-level add amount. Nibble n is for level n. Each nibble is 0–9.
- PENALTY, {4'd8,4'd5,4'd3,4'd1}: packed per-level subtract amount. Nibble n is for level n. Each nibble is 0–9.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous score clear; best is kept.
- hit  in  1  add event; sampled only when ready=1.
- miss  in  1  subtract event; sampled only when ready=1.
- level  in  2  difficulty level; sampled at accept.
- ready  out  1  registered; 1 when idle and able to accept an event.
- score  out  4*DIGITS  committed packed-BCD score; digit 0 is in bits [3:0].
- best  out  4*DIGITS  highest committed score since reset.
- done  out  1  one-cycle pulse when a new score is committed.
- sat  out  1  one-cycle pulse, coincident with done, when the result was clamped.

## Operation
- FSM states: IDLE, RUN, COMMIT.
- Accept: an event is accepted when state=IDLE and exactly one of hit/miss is 1, with clear=0.
  - On accept, latch the operation (add/sub), latch the operand nibble REWARD[level] or PENALTY[level], copy score into the working register, set digit index=0, set carry=0, and go to RUN.
- hit and miss both high in IDLE: ignored, no operation.
- Events while ready=0: dropped, not queued.
- RUN: each cycle processes working digit[idx].
  - Add: s = d + opnd + carry (opnd is applied only when idx=0, else 0). If s>9, digit = s−10 and carry=1; else digit = s and carry=0.
  - Sub: t = d − opnd − borrow. If t<0, digit = t+10 and borrow=1; else digit = t and borrow=0.
  - Use 5-bit intermediates.
  - idx increments each cycle. After digit DIGITS−1, go to COMMIT.
- COMMIT:
  - If carry out of the MSD on add, score = all 9s and sat=1.
  - If borrow out of the MSD on sub, score = all 0s and sat=1.
  - Otherwise score = working register.
  - If the new score > best (unsigned compare of packed nibbles), best is updated.
  - done=1, then return to IDLE.
- Operand 0 is legal: the operation runs full length and score is unchanged.
- clear, in any state: at the next edge, score = 0, the FSM goes to IDLE, any in-flight op is aborted with no done and no sat, and best is unchanged.
  - clear has priority over hit/miss.
- rst: at the next edge, score = 0, best = 0, state = IDLE, ready = 1, done = 0, sat = 0, working regs = 0.
  - rst has priority over clear.
- Inputs score digits are always valid BCD, since only this block writes them.

## Timing
- Accept edge E0; level, hit and miss are sampled here. ready=0 from E0 until E0+DIGITS+1.
- RUN edges: E0+1 … E0+DIGITS.
- The COMMIT edge is E0+DIGITS+1. score and best update here, done and sat are high for the cycle following it, and ready returns to 1.
- The earliest next accept is E0+DIGITS+2. Throughput is one event per DIGITS+2 cycles.
- Latency from accept to new score is DIGITS+1 cycles. score holds its old value throughout RUN.
- done and sat are never high for more than one consecutive cycle. They are low after rst and after clear.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst for 2 cycles → score=0000, best=0000, ready=1, done=0, sat=0. Pulse hit during rst → no change.
- Carry ripple: score 0999, level 0 hit → at E0+5, score=1000, done=1 for one cycle, sat=0, best=1000. Then level 1 miss → 0997, best stays 1000.
- Upper saturation: score 9998, level 3 hit (+4) → 9999, sat=1, done=1, best=9999.
- Lower saturation: score 0002, level 2 miss (−5) → 0000, sat=1. Also: score 0000, level 0 miss → 0000, sat=1.
- Handshake:
  - hit while ready=0 → dropped; the only result is the first op.
  - hit and miss together in IDLE → no op, ready stays 1.
  - Back-to-back hits every cycle from 0000 at level 0 → one accept per 6 cycles, score increments by 1 each time.
- Clear mid-op: score 0500, level 3 hit, assert clear at E0+2 → score=0000 next edge, no done, best unchanged, ready=1, and a subsequent hit works normally. Repeat with DIGITS=6 and check latency is 7 cycles.
